// File: rtl/wb_slot_ctrl_if.sv
// Bus bundle for wb_slot_ctrl: host-side Wishbone classic port plus the four fanned-out slot ports.
// The controller uses the slave modport; whatever drives the host side and models the slots uses master.
interface wb_slot_ctrl_if;
    // host side
    logic         wbs_cyc_i;
    logic         wbs_stb_i;
    logic         wbs_we_i;
    logic [3:0]   wbs_sel_i;
    logic [31:0]  wbs_adr_i;
    logic [31:0]  wbs_dat_i;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    // slot side
    logic [3:0]   slot_cyc_o;
    logic [3:0]   slot_stb_o;
    logic         slot_we_o;
    logic [3:0]   slot_sel_o;
    logic [31:0]  slot_adr_o;
    logic [31:0]  slot_dat_o;
    logic [3:0]   slot_ack_i;
    logic [127:0] slot_dat_i;
    // status
    logic [3:0]   slot_en_o;
    logic         err_irq_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        output slot_cyc_o, slot_stb_o, slot_we_o, slot_sel_o, slot_adr_o, slot_dat_o,
        input  slot_ack_i, slot_dat_i,
        output slot_en_o, err_irq_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        input  slot_cyc_o, slot_stb_o, slot_we_o, slot_sel_o, slot_adr_o, slot_dat_o,
        output slot_ack_i, slot_dat_i,
        input  slot_en_o, err_irq_o
    );
endinterface

// File: rtl/wb_slot_ctrl.sv
// Wishbone controller that forwards host transactions to one of four user slots, with a
// per-slot enable CSR, bounded slot response time and a counted, sticky error report.
module wb_slot_ctrl #(
    parameter int unsigned SLOT_LSB = 16,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
    parameter logic [31:0] CSR_ADDR = 32'h3000_FFFC
) (
    input logic           wb_clk_i,
    input logic           wb_rst_i,
    wb_slot_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FWD  = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  slot_q, slot_d;
    logic [3:0]  cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [15:0] timer_q, timer_d;
    logic        ack_q, ack_d;
    logic [31:0] rdat_q, rdat_d;
    logic [3:0]  en_q, en_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [1:0]  last_err_q, last_err_d;
    logic        irq_q, irq_d;

    logic        req;
    logic        csr_hit;
    logic [1:0]  req_slot;
    logic [31:0] csr_rd;
    logic [31:0] slot_rd;
    logic        rec_err;
    logic [1:0]  err_slot;

    assign req      = bus.wbs_cyc_i & bus.wbs_stb_i;
    assign csr_hit  = (bus.wbs_adr_i == CSR_ADDR);
    assign req_slot = bus.wbs_adr_i[SLOT_LSB +: 2];
    assign csr_rd   = {14'd0, last_err_q, err_cnt_q, 4'd0, en_q};
    assign slot_rd  = bus.slot_dat_i[{slot_q, 5'd0} +: 32];

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        timer_d    = timer_q;
        en_d       = en_q;
        err_cnt_d  = err_cnt_q;
        last_err_d = last_err_q;
        irq_d      = irq_q;
        // ack and read data are single-cycle pulses; they default back to zero
        ack_d      = 1'b0;
        rdat_d     = 32'd0;
        rec_err    = 1'b0;
        err_slot   = slot_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (csr_hit) begin
                        rdat_d  = csr_rd;
                        ack_d   = 1'b1;
                        state_d = ACK;
                        if (bus.wbs_we_i) begin
                            if (bus.wbs_sel_i[0]) begin
                                en_d = bus.wbs_dat_i[3:0];
                            end
                            if (bus.wbs_sel_i[3] && bus.wbs_dat_i[24]) begin
                                err_cnt_d = 8'd0;
                                irq_d     = 1'b0;
                            end
                        end
                    end else if (!en_q[req_slot]) begin
                        rdat_d   = ERR_DATA;
                        ack_d    = 1'b1;
                        rec_err  = 1'b1;
                        err_slot = req_slot;
                        state_d  = ACK;
                    end else begin
                        slot_d  = req_slot;
                        we_d    = bus.wbs_we_i;
                        sel_d   = bus.wbs_sel_i;
                        adr_d   = bus.wbs_adr_i;
                        wdat_d  = bus.wbs_dat_i;
                        cyc_d   = 4'b0001 << req_slot;
                        timer_d = 16'd0;
                        state_d = FWD;
                    end
                end
            end
            FWD: begin
                if (!bus.wbs_cyc_i) begin
                    // host abandoned the cycle: quietly release the slot
                    cyc_d   = 4'd0;
                    state_d = IDLE;
                end else if (bus.slot_ack_i[slot_q]) begin
                    rdat_d  = slot_rd;
                    ack_d   = 1'b1;
                    cyc_d   = 4'd0;
                    state_d = ACK;
                end else if (timer_q == TIMER_LAST) begin
                    rdat_d  = ERR_DATA;
                    ack_d   = 1'b1;
                    cyc_d   = 4'd0;
                    rec_err = 1'b1;
                    state_d = ACK;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                cyc_d   = 4'd0;
                state_d = IDLE;
            end
        endcase

        if (rec_err) begin
            err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            last_err_d = err_slot;
            irq_d      = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            slot_q     <= 2'd0;
            cyc_q      <= 4'd0;
            we_q       <= 1'b0;
            sel_q      <= 4'd0;
            adr_q      <= 32'd0;
            wdat_q     <= 32'd0;
            timer_q    <= 16'd0;
            ack_q      <= 1'b0;
            rdat_q     <= 32'd0;
            en_q       <= 4'b1111;
            err_cnt_q  <= 8'd0;
            last_err_q <= 2'd0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            timer_q    <= timer_d;
            ack_q      <= ack_d;
            rdat_q     <= rdat_d;
            en_q       <= en_d;
            err_cnt_q  <= err_cnt_d;
            last_err_q <= last_err_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.wbs_ack_o  = ack_q;
    assign bus.wbs_dat_o  = rdat_q;
    assign bus.slot_cyc_o = cyc_q;
    assign bus.slot_stb_o = cyc_q;
    assign bus.slot_we_o  = we_q;
    assign bus.slot_sel_o = sel_q;
    assign bus.slot_adr_o = adr_q;
    assign bus.slot_dat_o = wdat_q;
    assign bus.slot_en_o  = en_q;
    assign bus.err_irq_o  = irq_q;

endmodule

// File: tb/tb_wb_slot_ctrl.sv
// Self-checking bench for wb_slot_ctrl: directed vector table, corner-case sequences and
// randomized traffic compared against a transaction-level model of the controller.
module tb_wb_slot_ctrl;

    localparam int          TO   = 255;
    localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
    localparam logic [31:0] CSR  = 32'h3000_FFFC;
    localparam int          NEVER = 100000;

    logic clk;
    logic rst;

    wb_slot_ctrl_if bus ();

    wb_slot_ctrl #(
        .SLOT_LSB (16),
        .TIMEOUT  (TO),
        .ERR_DATA (ERR),
        .CSR_ADDR (CSR)
    ) u_dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // slot responders: slot s acks in its (dly[s]+1)-th stb cycle
    int          dly [4];
    logic [31:0] sdat [4];
    logic [3:0]  ack_force;
    int          cnt [4];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) cnt[i] <= 0;
            else     cnt[i] <= bus.slot_stb_o[i] ? cnt[i] + 1 : 0;
        end
    end

    always_comb begin
        bus.slot_ack_i = '0;
        bus.slot_dat_i = '0;
        for (int i = 0; i < 4; i++) begin
            bus.slot_ack_i[i]        = (bus.slot_stb_o[i] && cnt[i] == dly[i]) || ack_force[i];
            bus.slot_dat_i[32*i +: 32] = sdat[i];
        end
    end

    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // transaction-level model
    logic [3:0] m_en;
    int         m_cnt;
    int         m_last;
    logic       m_irq;

    task automatic model_reset();
        m_en = 4'hF; m_cnt = 0; m_last = 0; m_irq = 1'b0;
    endtask

    task automatic model(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] dat, output logic [31:0] erd, output int elat);
        int s;
        bit err;
        err = 0;
        s   = int'(adr[17:16]);
        if (adr == CSR) begin
            erd  = 32'(m_last * 65536 + m_cnt * 256 + int'(m_en));
            elat = 1;
            if (we) begin
                if (sel[0]) m_en = dat[3:0];
                if (sel[3] && dat[24]) begin m_cnt = 0; m_irq = 1'b0; end
            end
        end else if (!m_en[s]) begin
            erd = ERR; elat = 1; err = 1;
        end else if (dly[s] + 1 <= TO) begin
            erd = sdat[s]; elat = dly[s] + 2;
        end else begin
            erd = ERR; elat = TO + 1; err = 1;
        end
        if (err) begin
            if (m_cnt < 255) m_cnt++;
            m_last = s;
            m_irq  = 1'b1;
        end
    endtask

    // one host transaction; returns data, latency and observed slot activity
    task automatic xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat, output logic [31:0] rd, output int lat,
                        output logic [3:0] seen_cyc, output int stb_cyc,
                        output logic [31:0] seen_adr);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_sel_i = sel;  bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;
        lat = 0; seen_cyc = 4'd0; stb_cyc = 0; seen_adr = 32'd0; rd = 32'd0;
        do begin
            tick();
            lat++;
            seen_cyc |= bus.slot_cyc_o;
            if (|bus.slot_stb_o) begin
                stb_cyc++;
                seen_adr = bus.slot_adr_o;
            end
        end while (!bus.wbs_ack_o && lat < 400);
        if (!bus.wbs_ack_o) chk("ack_wait_bound", 32'(lat), 32'd0);
        rd = bus.wbs_dat_o;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        tick();
        chk("ack_single_cycle", {bus.wbs_ack_o, bus.wbs_dat_o[30:0]}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          sdly;
        logic [31:0] srd;
        logic        chk_dat;
        logic [31:0] exp_dat;
        int          exp_lat;
        logic [3:0]  exp_cyc;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [10];

    logic [31:0] rd, erd, sa, a;
    int          lat, elat, stbc, s;
    logic [3:0]  sc;
    logic        saw_ack;

    initial begin
        checks = 0; errors = 0;
        ack_force = 4'd0;
        for (int i = 0; i < 4; i++) begin dly[i] = 0; sdat[i] = 32'd0; end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'd0; bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0;
        model_reset();

        tbl[0] = '{CSR,          1'b0, 4'hF, 32'h0,         0, 32'h0,         1'b1, 32'h0000_000F, 1, 4'b0000, 1'b0};
        tbl[1] = '{32'h3002_0010, 1'b0, 4'hF, 32'h0,         3, 32'h1234_5678, 1'b1, 32'h1234_5678, 5, 4'b0100, 1'b0};
        tbl[2] = '{CSR,          1'b1, 4'h1, 32'h0000_000D, 0, 32'h0,         1'b0, 32'h0,         1, 4'b0000, 1'b0};
        tbl[3] = '{32'h3001_0000, 1'b1, 4'hF, 32'h5555_AAAA, 0, 32'h0,         1'b1, ERR,           1, 4'b0000, 1'b1};
        tbl[4] = '{CSR,          1'b0, 4'hF, 32'h0,         0, 32'h0,         1'b1, 32'h0001_010D, 1, 4'b0000, 1'b1};
        tbl[5] = '{CSR,          1'b1, 4'h1, 32'h0000_000F, 0, 32'h0,         1'b0, 32'h0,         1, 4'b0000, 1'b1};
        tbl[6] = '{CSR,          1'b1, 4'h8, 32'h0100_0000, 0, 32'h0,         1'b0, 32'h0,         1, 4'b0000, 1'b0};
        tbl[7] = '{CSR,          1'b0, 4'hF, 32'h0,         0, 32'h0,         1'b1, 32'h0001_000F, 1, 4'b0000, 1'b0};
        tbl[8] = '{32'h3000_0040, 1'b1, 4'hF, 32'hA5A5_0001, 0, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 2, 4'b0001, 1'b0};
        tbl[9] = '{32'h3003_1234, 1'b0, 4'h3, 32'h0,         1, 32'hCAFE_0003, 1'b1, 32'hCAFE_0003, 3, 4'b1000, 1'b0};

        rst = 1'b1;
        tick(); tick();
        chk("rst_slot_en", 32'(bus.slot_en_o), 32'h0000_000F);
        chk("rst_outputs", {bus.wbs_ack_o, bus.err_irq_o, bus.slot_cyc_o, bus.slot_stb_o,
                            bus.slot_we_o, bus.slot_sel_o}, 32'd0);
        chk("rst_dat", bus.wbs_dat_o | bus.slot_adr_o | bus.slot_dat_o, 32'd0);
        rst = 1'b0;
        tick();

        // directed table
        for (int i = 0; i < 10; i++) begin
            s = int'(tbl[i].adr[17:16]);
            if (tbl[i].adr != CSR) begin dly[s] = tbl[i].sdly; sdat[s] = tbl[i].srd; end
            model(tbl[i].adr, tbl[i].we, tbl[i].sel, tbl[i].dat, erd, elat);
            xfer(tbl[i].adr, tbl[i].we, tbl[i].sel, tbl[i].dat, rd, lat, sc, stbc, sa);
            if (tbl[i].chk_dat) chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp_dat);
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
            chk($sformatf("tbl%0d_slot_cyc", i), 32'(sc), 32'(tbl[i].exp_cyc));
            chk($sformatf("tbl%0d_irq", i), 32'(bus.err_irq_o), 32'(tbl[i].exp_irq));
            if (tbl[i].exp_cyc != 4'd0) begin
                chk($sformatf("tbl%0d_slot_adr", i), sa, tbl[i].adr);
                chk($sformatf("tbl%0d_slot_we_sel", i), {27'd0, bus.slot_we_o, bus.slot_sel_o},
                    {27'd0, tbl[i].we, tbl[i].sel});
                chk($sformatf("tbl%0d_slot_wdat", i), bus.slot_dat_o, tbl[i].dat);
            end
        end
        chk("tbl_slot_en", 32'(bus.slot_en_o), 32'h0000_000F);

        // slot 3 never acks: full timeout
        dly[3] = NEVER;
        model(32'h3003_0000, 1'b0, 4'hF, 32'h0, erd, elat);
        xfer(32'h3003_0000, 1'b0, 4'hF, 32'h0, rd, lat, sc, stbc, sa);
        chk("to_data", rd, ERR);
        chk("to_latency", 32'(lat), 32'(TO + 1));
        chk("to_stb_cycles", 32'(stbc), 32'(TO));
        model(CSR, 1'b0, 4'hF, 32'h0, erd, elat);
        xfer(CSR, 1'b0, 4'hF, 32'h0, rd, lat, sc, stbc, sa);
        chk("to_csr", rd, 32'h0003_010F);

        // slot 0 acks on the expiry cycle while slot 1 acks spuriously
        dly[0] = TO - 1; sdat[0] = 32'h5A5A_0000; ack_force = 4'b0010;
        model(32'h3000_0008, 1'b0, 4'hF, 32'h0, erd, elat);
        xfer(32'h3000_0008, 1'b0, 4'hF, 32'h0, rd, lat, sc, stbc, sa);
        ack_force = 4'd0;
        chk("edge_data", rd, 32'h5A5A_0000);
        chk("edge_latency", 32'(lat), 32'(TO + 1));
        model(CSR, 1'b0, 4'hF, 32'h0, erd, elat);
        xfer(CSR, 1'b0, 4'hF, 32'h0, rd, lat, sc, stbc, sa);
        chk("edge_csr", rd, 32'h0003_010F);

        // host abandons the cycle mid-forward
        dly[2] = NEVER;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = 32'h3002_0000;
        saw_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(); saw_ack |= bus.wbs_ack_o; end
        chk("drop_cyc_before", 32'(bus.slot_cyc_o), 32'h4);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        tick();
        chk("drop_cyc_after", 32'(bus.slot_cyc_o | bus.slot_stb_o), 32'h0);
        for (int i = 0; i < 3; i++) begin tick(); saw_ack |= bus.wbs_ack_o; end
        chk("drop_no_ack", 32'(saw_ack), 32'h0);
        model(CSR, 1'b0, 4'hF, 32'h0, erd, elat);
        xfer(CSR, 1'b0, 4'hF, 32'h0, rd, lat, sc, stbc, sa);
        chk("drop_csr", rd, 32'h0003_010F);

        // randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            logic        we;
            logic [3:0]  sel;
            logic [31:0] dat;
            int          kind;
            kind = int'($urandom_range(0, 19));
            we   = 1'($urandom);
            sel  = 4'($urandom);
            dat  = $urandom;
            if (kind < 3) begin
                a = CSR; we = 1'b0;
            end else if (kind < 5) begin
                a = CSR; we = 1'b1;
                if (kind == 4) dat[3:0] = dat[3:0] | 4'b0011;
            end else begin
                s = int'($urandom_range(0, 3));
                a = $urandom;
                a[17:16] = 2'(s);
                if (a == CSR) a[2] = ~a[2];
                dly[s]  = ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(0, 6));
                sdat[s] = $urandom;
            end
            model(a, we, sel, dat, erd, elat);
            xfer(a, we, sel, dat, rd, lat, sc, stbc, sa);
            if (!(a == CSR && we)) chk($sformatf("rnd%0d_data", n), rd, erd);
            chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(elat));
            chk($sformatf("rnd%0d_irq_en", n), {27'd0, bus.err_irq_o, bus.slot_en_o},
                {27'd0, m_irq, m_en});
        end

        // error counter saturation, then write-1-clear
        model(CSR, 1'b1, 4'h1, 32'h0000_000F, erd, elat);
        xfer(CSR, 1'b1, 4'h1, 32'h0000_000F, rd, lat, sc, stbc, sa);
        dly[3] = NEVER;
        for (int n = 0; n < 260; n++) begin
            model(32'h3003_0100, 1'b0, 4'hF, 32'h0, erd, elat);
            xfer(32'h3003_0100, 1'b0, 4'hF, 32'h0, rd, lat, sc, stbc, sa);
        end
        chk("sat_last_data", rd, ERR);
        model(CSR, 1'b0, 4'hF, 32'h0, erd, elat);
        xfer(CSR, 1'b0, 4'hF, 32'h0, rd, lat, sc, stbc, sa);
        chk("sat_csr", rd, 32'h0003_FF0F);
        chk("sat_irq", 32'(bus.err_irq_o), 32'h1);
        model(CSR, 1'b1, 4'h8, 32'h0100_0000, erd, elat);
        xfer(CSR, 1'b1, 4'h8, 32'h0100_0000, rd, lat, sc, stbc, sa);
        chk("w1c_irq", 32'(bus.err_irq_o), 32'h0);
        model(CSR, 1'b0, 4'hF, 32'h0, erd, elat);
        xfer(CSR, 1'b0, 4'hF, 32'h0, rd, lat, sc, stbc, sa);
        chk("w1c_csr", rd, 32'h0003_000F);

        // async reset in the middle of a forwarded cycle, away from any clock edge
        dly[1] = NEVER;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = 32'h3001_0000;
        tick(); tick(); tick();
        chk("arst_before", 32'(bus.slot_cyc_o), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cyc", 32'(bus.slot_cyc_o | bus.slot_stb_o), 32'h0);
        chk("arst_ack", 32'(bus.wbs_ack_o), 32'h0);
        chk("arst_en", 32'(bus.slot_en_o), 32'hF);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        model(CSR, 1'b0, 4'hF, 32'h0, erd, elat);
        xfer(CSR, 1'b0, 4'hF, 32'h0, rd, lat, sc, stbc, sa);
        chk("arst_csr", rd, 32'h0000_000F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
